// File: rtl/barcodescanner_pkg.sv
// Shared types and constants for the barcode scanner capture path.
package barcodescanner_pkg;

    localparam int LANES  = 4;
    localparam int PIX_W  = 8;
    localparam int WORD_W = LANES * PIX_W;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOP,
        ST_PACK,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs consecutive pixels into one word, lane 0 first, tracking which byte lanes hold data.
module pixel_word_packer
    import barcodescanner_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [PIX_W-1:0]  i_pix,
    output logic [WORD_W-1:0] o_data,
    output logic [LANES-1:0]  o_be,
    output logic              o_last_lane
);

    logic [LANE_W-1:0] r_lane;
    logic [PIX_W-1:0]  r_byte [LANES];
    logic              r_be   [LANES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
        end else if (i_load) begin
            r_lane <= r_lane + LANE_W'(1);
        end
    end

    assign o_last_lane = (r_lane == LANE_W'(LANES - 1));

    // Unfilled lanes stay zero so a short final word carries no stale bytes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_byte[gi] <= '0;
                    r_be[gi]   <= 1'b0;
                end else if (i_clear) begin
                    r_byte[gi] <= '0;
                    r_be[gi]   <= 1'b0;
                end else if (i_load && (r_lane == LANE_W'(gi))) begin
                    r_byte[gi] <= i_pix;
                    r_be[gi]   <= 1'b1;
                end
            end

            assign o_data[gi*PIX_W +: PIX_W] = r_byte[gi];
            assign o_be[gi]                  = r_be[gi];
        end
    endgenerate

endmodule

// File: rtl/pixel_frame_writer.sv
// Avalon-MM write master that packs a grayscale pixel stream into frame memory,
// one 32-bit word per four pixels, and flags short or long frames.
module pixel_frame_writer
    import barcodescanner_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              short_frame,
    output logic              long_frame,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    input  logic              pix_sop,
    input  logic              pix_eop,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [WORD_W-1:0] m_writedata,
    output logic [LANES-1:0]  m_byteenable,
    input  logic              m_waitrequest
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_pix_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic              r_eop_seen;
    logic              r_short;
    logic              r_long;

    logic             w_accept;
    logic             w_start_ok;
    logic             w_pack_pix;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_hit_limit;
    logic             w_last_lane;
    logic             w_close;
    logic             w_wr_done;
    logic             w_clear;

    assign w_accept    = pix_valid & pix_ready;
    assign w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_pack_pix  = w_accept & (((r_state == ST_WAIT_SOP) & pix_sop) | (r_state == ST_PACK));
    assign w_count_inc = r_pix_count + CNT_W'(1);
    assign w_hit_limit = (w_count_inc == CNT_W'(FRAME_PIXELS));
    assign w_close     = w_pack_pix & (w_last_lane | pix_eop | w_hit_limit);
    assign w_wr_done   = (r_state == ST_WRITE) & ~m_waitrequest;
    assign w_clear     = w_start_ok | w_wr_done;

    pixel_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_pack_pix),
        .i_pix       (pix_data),
        .o_data      (m_writedata),
        .o_be        (m_byteenable),
        .o_last_lane (w_last_lane)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                // A sop pixel may also close the word (single-pixel or sop+eop frame).
                if (w_pack_pix) w_state_next = w_close ? ST_WRITE : ST_PACK;
            end
            ST_PACK: begin
                if (w_close) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_wr_done) begin
                    if (r_eop_seen)
                        w_state_next = ST_DONE;
                    else if (r_pix_count == CNT_W'(FRAME_PIXELS))
                        w_state_next = ST_DRAIN;
                    else
                        w_state_next = ST_PACK;
                end
            end
            ST_DRAIN: begin
                if (w_accept && pix_eop) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = start ? ST_WAIT_SOP : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        m_write   = 1'b0;
        case (r_state)
            ST_WAIT_SOP: begin pix_ready = 1'b1; busy = 1'b1; end
            ST_PACK:     begin pix_ready = 1'b1; busy = 1'b1; end
            ST_WRITE:    begin m_write   = 1'b1; busy = 1'b1; end
            ST_DRAIN:    begin pix_ready = 1'b1; busy = 1'b1; end
            ST_DONE:     done = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_count <= '0;
            r_word_idx  <= '0;
            r_eop_seen  <= 1'b0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else if (w_start_ok) begin
            r_pix_count <= '0;
            r_word_idx  <= '0;
            r_eop_seen  <= 1'b0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            if (w_pack_pix) begin
                r_pix_count <= w_count_inc;
                if (pix_eop) begin
                    r_eop_seen <= 1'b1;
                    if (!w_hit_limit) r_short <= 1'b1;
                end
            end
            if (w_wr_done) r_word_idx <= r_word_idx + ADDR_W'(1);
            if ((r_state == ST_DRAIN) && w_accept) r_long <= 1'b1;
        end
    end

    assign m_address   = ADDR_W'(BASE_ADDR) + r_word_idx;
    assign short_frame = r_short;
    assign long_frame  = r_long;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Scoreboard bench for pixel_frame_writer: directed frames push expected writes, a monitor checks them.
module tb_pixel_frame_writer;

    localparam int ADDR_W = 17;
    localparam int BASE   = 32'h100;
    localparam int FP     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              short_frame;
    logic              long_frame;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_sop;
    logic              pix_eop;
    logic              pix_ready;
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest;

    pixel_frame_writer #(
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .short_frame   (short_frame),
        .long_frame    (long_frame),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_sop       (pix_sop),
        .pix_eop       (pix_eop),
        .pix_ready     (pix_ready),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] be;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp      = 0;
    int          n_bad      = 0;
    int          done_cnt   = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic [31:0] prev_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] b);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be   = b;
        exp_q.push_back(w);
    endtask

    // Monitor: checks every completed write, stall stability and done pulses.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (m_write && m_waitrequest) begin
                    stall_seen++;
                    chk("stall_pix_ready", 32'(pix_ready), 32'd0);
                    if (prev_stall) begin
                        chk("stall_addr_stable", 32'(m_address), prev_addr);
                        chk("stall_data_stable", m_writedata, prev_data);
                        chk("stall_be_stable", 32'(m_byteenable), prev_be);
                    end
                end
                if (m_write && !m_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h required none",
                                 m_address, m_writedata, m_byteenable);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(m_address), e.addr);
                        chk("wr_data", m_writedata, e.data);
                        chk("wr_be", 32'(m_byteenable), e.be);
                    end
                end
                prev_stall = m_write && m_waitrequest;
                prev_addr  = 32'(m_address);
                prev_data  = m_writedata;
                prev_be    = 32'(m_byteenable);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        pix_data  = d;
        pix_sop   = s;
        pix_eop   = e;
        pix_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                @(posedge clk);
                #1;
                pix_valid = 1'b0;
                pix_sop   = 1'b0;
                pix_eop   = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no pix_ready for pixel 0x%0h required ready within 100 cycles", d);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] first, input int count, input int eop_at);
        for (int i = 1; i <= count; i++)
            send(first + 8'(i - 1), (i == 1), (i == eop_at));
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                chk("busy_low_at_done", 32'(busy), 32'd0);
                n = i;
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done pulse required one within 50 cycles");
        @(posedge clk);
        #1;
    endtask

    task automatic check_end(input string tag, input logic exp_short, input logic exp_long);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_short_frame"}, 32'(short_frame), 32'(exp_short));
        chk({tag, "_long_frame"}, 32'(long_frame), 32'(exp_long));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic stall_first_write();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (m_write) begin
                m_waitrequest = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                m_waitrequest = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL stall_timeout: got no m_write required one within 200 cycles");
    endtask

    int n;

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        pix_data      = 8'h00;
        pix_valid     = 1'b0;
        pix_sop       = 1'b0;
        pix_eop       = 1'b0;
        m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_short", 32'(short_frame), 32'd0);
        chk("rst_long", 32'(long_frame), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_address", 32'(m_address), 32'h100);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_m_byteenable", 32'(m_byteenable), 32'd0);
        @(posedge clk);
        #1;

        // Full frame, exact length.
        done_cnt = 0;
        push_wr(32'h100, 32'h04030201, 32'hF);
        push_wr(32'h101, 32'h08070605, 32'hF);
        pulse_start();
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        frame(8'h01, 8, 8);
        wait_done(n);
        chk("t1_done_latency", 32'(n), 32'd1);
        check_end("t1", 1'b0, 1'b0);

        // Short frame: eop on pixel 6.
        done_cnt = 0;
        push_wr(32'h100, 32'h04030201, 32'hF);
        push_wr(32'h101, 32'h00000605, 32'h3);
        pulse_start();
        frame(8'h01, 6, 6);
        wait_done(n);
        check_end("t2", 1'b1, 1'b0);

        // Three-cycle waitrequest on the first write.
        done_cnt   = 0;
        stall_seen = 0;
        push_wr(32'h100, 32'h04030201, 32'hF);
        push_wr(32'h101, 32'h08070605, 32'hF);
        pulse_start();
        fork
            stall_first_write();
        join_none
        frame(8'h01, 8, 8);
        wait_done(n);
        check_end("t3", 1'b0, 1'b0);
        chk("t3_stall_cycles", 32'(stall_seen), 32'd3);

        // Long frame: 10 pixels, eop on the 10th.
        done_cnt = 0;
        push_wr(32'h100, 32'h24232221, 32'hF);
        push_wr(32'h101, 32'h28272625, 32'hF);
        pulse_start();
        frame(8'h21, 10, 10);
        wait_done(n);
        chk("t4_done_after_eop", 32'(n), 32'd0);
        check_end("t4", 1'b0, 1'b1);

        // Reset while a write is pending.
        m_waitrequest = 1'b1;
        pulse_start();
        frame(8'h31, 4, 0);
        chk("t5_m_write_pending", 32'(m_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_m_write_dropped", 32'(m_write), 32'd0);
        chk("t5_busy_cleared", 32'(busy), 32'd0);
        chk("t5_pix_ready_cleared", 32'(pix_ready), 32'd0);
        chk("t5_be_cleared", 32'(m_byteenable), 32'd0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        m_waitrequest = 1'b0;
        @(posedge clk);
        #1;

        // Pre-sop pixels dropped, start while busy ignored, writes restart at base.
        done_cnt = 0;
        push_wr(32'h100, 32'h14131211, 32'hF);
        push_wr(32'h101, 32'h18171615, 32'hF);
        pulse_start();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0);
        pulse_start();
        for (int i = 0; i < 5; i++)
            send(8'h11 + 8'(i), (i == 0), 1'b0);
        chk("t6_busy_mid_frame", 32'(busy), 32'd1);
        pulse_start();
        send(8'h16, 1'b0, 1'b0);
        send(8'h17, 1'b0, 1'b0);
        send(8'h18, 1'b0, 1'b1);
        wait_done(n);
        check_end("t6", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
# pixel_frame_writer

Avalon-MM write master that fills the on-chip frame memory from the camera pixel stream. It accepts 8-bit grayscale pixels on a valid/ready stream and packs four pixels per 32-bit word, little-endian by byte lane. It writes each word to consecutive word addresses starting at a programmable base. It sits between the camera capture front end and the frame-memory slave port, and signals frame completion to the Nios-side barcode decoder.

## Interface
Parameters:
- ADDR_W, 17, word-address width; matches the frame memory.
- BASE_ADDR, 0, word address of pixel 0.
- FRAME_PIXELS, 76800, pixels per frame; must be ≥1. BASE_ADDR + ceil(FRAME_PIXELS/4) must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms capture of one frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word write completes.
- short_frame  out  1  sticky until next start; eop arrived before FRAME_PIXELS pixels.
- long_frame  out  1  sticky until next start; pixels arrived beyond FRAME_PIXELS before eop.
- pix_data  in  8  pixel value.
- pix_valid  in  1  pixel present.
- pix_sop  in  1  first pixel of a frame.
- pix_eop  in  1  last pixel of a frame.
- pix_ready  out  1  a pixel is accepted when pix_valid & pix_ready.
- m_address  out  ADDR_W  word address.
- m_write  out  1  write request.
- m_writedata  out  32  packed pixels; pixel n goes to bits [8(n%4)+7 : 8(n%4)].
- m_byteenable  out  4  valid byte lanes.
- m_waitrequest  in  1  slave stall; tie to 0 for a zero-wait memory.

## Operation
- States: IDLE, WAIT_SOP, PACK, WRITE, DRAIN, DONE.
- IDLE: pix_ready=0. Start moves to WAIT_SOP, clears both error flags, sets the word index to 0 and the lane to 0.
- WAIT_SOP: pix_ready=1. Pixels without sop are accepted and discarded. A pixel with sop is packed into lane 0, and the state moves to PACK.
- PACK: pix_ready=1. Each accepted pixel goes into the current lane and sets that byteenable bit. The block moves to WRITE when any of these holds:
  - lane 3 has been filled;
  - an accepted pixel carries eop;
  - the pixel count reaches FRAME_PIXELS.
- WRITE: pix_ready=0.
  - Drive m_write=1 with m_address = BASE_ADDR + word index.
  - The write completes on the first cycle with m_waitrequest=0.
  - On completion: increment the word index, clear the lanes and byteenable, and pick the next state:
    - more pixels still due → PACK;
    - frame ended by eop → DONE;
    - count limit reached without eop → DRAIN.
- DRAIN: pix_ready=1, sets long_frame on the first accepted pixel, discards pixels through eop, then goes to DONE.
- DONE: asserts done for one cycle, then returns to IDLE.
- If eop arrives with count < FRAME_PIXELS, short_frame is set. The partial word is written with only its filled lanes enabled. Unfilled lanes of m_writedata are 0.
- start is ignored whenever busy=1.
- sop inside PACK is treated as an ordinary pixel and does not restart the frame.

## Timing
- Reset values: busy=0, done=0, short_frame=0, long_frame=0, pix_ready=0, m_write=0, m_address=BASE_ADDR, m_writedata=0, m_byteenable=0. State is IDLE.
- Avalon rule: while m_write=1 and m_waitrequest=1, m_address, m_writedata and m_byteenable stay stable.
- m_write is registered. It rises the cycle after the word closes and falls the cycle after completion.
- Throughput with no waitrequest: 4 accept cycles plus 1 write cycle per full word.
- done pulses 1 cycle after the last write completes, or 1 cycle after eop is accepted in DRAIN. busy falls in the same cycle that done rises.
- Reset mid-frame clears everything immediately, including a pending m_write. No partial word is flushed.

## Structure
- The shared package `barcodescanner_pkg` holds the state enum, LANES=4 and PIX_W=8.
- Sub-module `pixel_word_packer` holds the lane counter, data and byteenable accumulation, and the clear operation. The FSM, counters and Avalon master logic live in the top module.

## Test plan
- FRAME_PIXELS=8, BASE_ADDR=0x100, pixels 0x01..0x08 with sop on the first and eop on the last:
  - writes 0x04030201 to 0x100 with byteenable 0xF;
  - writes 0x08070605 to 0x101 with byteenable 0xF;
  - done pulses once; both error flags stay 0.
- Same setup, eop on the 6th pixel: the second write is 0x00000605 with byteenable 0x3, and short_frame=1.
- m_waitrequest held high for 3 cycles on the first write: address, data and byteenable stay stable; pix_ready=0; exactly one write completes.
- 10 pixels, eop on the 10th: exactly two writes; pixels 9 and 10 are accepted and dropped; long_frame=1; done follows the eop.
- Reset asserted mid-frame during WRITE: m_write drops immediately and busy=0. A new start and frame then write from 0x100 again.
- Three pixels before sop are dropped, and a start pulse while busy is ignored: the words written contain only data from the sop pixel onward.
